// File: rtl/dc_segment_gen.sv
// dc_segment_gen: builds the delay-compensation distributed-data segment
// (link delay, status, topology ID) and drives it one byte per data slot.
module dc_segment_gen #(
    parameter int DELAY_WIDTH  = 32,
    parameter int PERIOD_SLOTS = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   slot,
    input  logic                   send,
    input  logic [7:0]             dbus_bits,
    input  logic [DELAY_WIDTH-1:0] delay,
    input  logic [2:0]             status,
    input  logic [31:0]            topoid,
    output logic [7:0]             tx_data,
    output logic                   tx_isk,
    output logic                   tx_valid,
    output logic                   busy,
    output logic                   done
);
    localparam logic [7:0]  K28_2         = 8'h5C;
    localparam logic [7:0]  K28_1         = 8'h3C;
    localparam logic [7:0]  ADDR_BYTE     = 8'hFF;
    localparam logic [31:0] PERIOD_RELOAD = (PERIOD_SLOTS > 0) ? 32'(PERIOD_SLOTS - 1) : 32'd0;

    // state_q names the phase of the byte currently presented on tx_data.
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_DATA, S_STOP, S_SUM_HI, S_SUM_LO
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [127:0]  payload_q, payload_d;
    logic [15:0]   csum_q, csum_d;
    logic [7:0]    tx_data_q, data_d;
    logic          tx_isk_q, isk_d;
    logic          tx_valid_q;
    logic          done_q;
    logic          pending_q, pending_d;
    logic [31:0]   per_cnt_q, per_cnt_d;
    logic          start;
    logic          expire;
    logic [31:0]   delay_ext;

    always_comb begin
        delay_ext = '0;
        delay_ext[DELAY_WIDTH-1:0] = delay;
    end

    // Byte sequencer: everything advances only on slot cycles.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        payload_d = payload_q;
        csum_d    = csum_q;
        data_d    = tx_data_q;
        isk_d     = tx_isk_q;
        start     = 1'b0;
        if (slot) begin
            isk_d = 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (pending_q || send) begin
                        start     = 1'b1;
                        state_d   = S_START;
                        data_d    = K28_2;
                        isk_d     = 1'b1;
                        payload_d = {delay_ext, 29'd0, status, 32'd0, topoid};
                        csum_d    = 16'hFFFF;
                    end else begin
                        data_d = dbus_bits;
                    end
                end
                S_START: begin
                    state_d = S_ADDR;
                    data_d  = ADDR_BYTE;
                    csum_d  = csum_q - {8'd0, ADDR_BYTE};
                end
                S_ADDR: begin
                    state_d = S_DATA;
                    cnt_d   = 4'd15;
                    data_d  = payload_q[127:120];
                    csum_d  = csum_q - {8'd0, payload_q[127:120]};
                end
                S_DATA: begin
                    if (cnt_q == 4'd0) begin
                        state_d = S_STOP;
                        data_d  = K28_1;
                        isk_d   = 1'b1;
                    end else begin
                        cnt_d  = cnt_q - 4'd1;
                        data_d = payload_q[{cnt_d, 3'b000} +: 8];
                        csum_d = csum_q - {8'd0, data_d};
                    end
                end
                S_STOP: begin
                    state_d = S_SUM_HI;
                    data_d  = csum_q[15:8];
                end
                S_SUM_HI: begin
                    state_d = S_SUM_LO;
                    data_d  = csum_q[7:0];
                end
                S_SUM_LO: begin
                    state_d = S_IDLE;
                    data_d  = dbus_bits;
                end
                default: begin
                    state_d = S_IDLE;
                    data_d  = dbus_bits;
                end
            endcase
        end
    end

    // Period counter raises a request on the slot it reaches zero, so the
    // following slot can issue START exactly PERIOD_SLOTS after the last one.
    always_comb begin
        per_cnt_d = per_cnt_q;
        expire    = 1'b0;
        if (PERIOD_SLOTS != 0 && slot) begin
            if (start) begin
                per_cnt_d = PERIOD_RELOAD;
                expire    = (PERIOD_SLOTS == 1);
            end else if (per_cnt_q != 32'd0) begin
                per_cnt_d = per_cnt_q - 32'd1;
                expire    = (per_cnt_q == 32'd1);
            end
        end
        pending_d = start ? expire : (pending_q | send | expire);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            payload_q  <= '0;
            csum_q     <= 16'hFFFF;
            tx_data_q  <= 8'h00;
            tx_isk_q   <= 1'b0;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            pending_q  <= 1'b0;
            per_cnt_q  <= PERIOD_RELOAD;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            payload_q  <= payload_d;
            csum_q     <= csum_d;
            tx_data_q  <= data_d;
            tx_isk_q   <= isk_d;
            tx_valid_q <= slot;
            done_q     <= slot && (state_d == S_SUM_LO);
            pending_q  <= pending_d;
            per_cnt_q  <= per_cnt_d;
        end
    end

    // tx_valid is a one-clk strobe after every slot edge; the consumer has no
    // way to stall, so tx_data/tx_isk must be taken while tx_valid is high.
    assign tx_data  = tx_data_q;
    assign tx_isk   = tx_isk_q;
    assign tx_valid = tx_valid_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;

endmodule
